// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------+
// | uart_pkg: register map, STATUS bit positions, transmitter FSM states   |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_DIVISOR = 2'd3;

  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_EMPTY_BIT = 2;
  localparam int STATUS_COUNT_LSB = 8;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_DATA  = 2'd2;
  localparam state_t ST_STOP  = 2'd3;

  // A programmed divisor of zero still needs a one-cycle bit period.
  function automatic logic [15:0] eff_divisor(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// +----------------------------------------------------------------------+
// | sync_fifo: single-clock FIFO with occupancy count and flags            |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_avalon.sv
// +----------------------------------------------------------------------+
// | uart_tx_avalon: Avalon-MM UART transmitter, byte FIFO, 8N1 framing    |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_tx_avalon
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_RESET  = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  avs_address,
  input  logic [3:0]  avs_byteenable,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic        avs_waitrequest,
  output logic        tx,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic        irq_en_q, irq_en_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic [15:0]   div_eff;
  logic          busy;
  logic          wr_ok;
  logic          unused_bits;

  // Stall only DATA writes against a full FIFO; full is a registered flag.
  assign avs_waitrequest = avs_write && (avs_address == ADDR_DATA) && fifo_full;
  assign wr_ok           = avs_write && !avs_waitrequest;
  assign fifo_push       = wr_ok && (avs_address == ADDR_DATA) && avs_byteenable[0];
  assign div_eff         = eff_divisor(div_q);
  assign busy            = (state_q != ST_IDLE);
  assign unused_bits     = ^{avs_writedata[31:16], avs_byteenable[3:2]};

  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign tx                = tx_q;
  assign irq               = irq_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (avs_writedata[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    div_d    = div_q;
    irq_en_d = irq_en_q;
    if (wr_ok && (avs_address == ADDR_CONTROL) && avs_byteenable[0]) begin
      irq_en_d = avs_writedata[0];
    end
    if (wr_ok && (avs_address == ADDR_DIVISOR)) begin
      if (avs_byteenable[0]) div_d[7:0]  = avs_writedata[7:0];
      if (avs_byteenable[1]) div_d[15:8] = avs_writedata[15:8];
    end
  end

  always_comb begin
    rvalid_d = avs_read;
    rdata_d  = '0;
    if (avs_read) begin
      case (avs_address)
        ADDR_STATUS: begin
          rdata_d[STATUS_BUSY_BIT]           = busy;
          rdata_d[STATUS_FULL_BIT]           = fifo_full;
          rdata_d[STATUS_EMPTY_BIT]          = fifo_empty;
          rdata_d[STATUS_COUNT_LSB +: 8]     = 8'(fifo_count);
        end
        ADDR_CONTROL: rdata_d[0]    = irq_en_q;
        ADDR_DIVISOR: rdata_d[15:0] = div_q;
        default:      rdata_d       = '0;
      endcase
    end
  end

  // Every state lasts div_eff cycles; the divisor is resampled at each bit boundary.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          cnt_d    = div_eff - 16'd1;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = div_eff - 16'd1;
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = div_eff - 16'd1;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        if (cnt_q == 16'd0) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            cnt_d    = div_eff - 16'd1;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
    endcase
  end

  always_comb begin
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
    irq_d = irq_en_q && fifo_empty && !busy;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      div_q    <= 16'(DIV_RESET);
      irq_en_q <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      irq_en_q <= irq_en_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_avalon.sv
// +----------------------------------------------------------------------+
// | tb_uart_tx_avalon: scoreboard bench with line-level frame reference   |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_avalon;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  avs_address = 2'd0;
  logic [3:0]  avs_byteenable = 4'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        avs_waitrequest;
  logic        tx;
  logic        irq;

  uart_tx_avalon #(
    .FIFO_DEPTH (16),
    .DIV_RESET  (434)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .avs_address       (avs_address),
    .avs_byteenable    (avs_byteenable),
    .avs_read          (avs_read),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_waitrequest   (avs_waitrequest),
    .tx                (tx),
    .irq               (irq)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic [7:0] data; int acc; int div; } frame_t;
  typedef struct { logic [31:0] data; int at; string name; } rd_t;

  frame_t exp_frames[$];
  rd_t    exp_reads[$];
  int     n_cmp = 0;
  int     n_fail = 0;
  int     prev_end = 0;
  bit     mon_busy = 1'b0;
  int     model_div = 434;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame monitor: a start bit must match the oldest accepted byte, begin at
  // max(accept+1, previous frame end), and hold each of 10 bits for div cycles.
  always begin
    @(negedge clock);
    if (!reset && tx === 1'b0) begin
      if (exp_frames.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_frame: start bit at cycle %0d, required idle line", cyc);
        for (int g = 0; g < 64 && tx !== 1'b1; g++) @(negedge clock);
      end else begin : frame_chk
        frame_t     f;
        int         st, es, errs, b;
        logic [7:0] got;
        logic       e;
        bit         ab;
        f        = exp_frames.pop_front();
        mon_busy = 1'b1;
        st       = cyc;
        errs     = 0;
        got      = 8'd0;
        ab       = 1'b0;
        es       = (f.acc + 1 > prev_end) ? f.acc + 1 : prev_end;
        for (int i = 0; i < 10 * f.div; i++) begin
          if (i != 0) @(negedge clock);
          if (reset) begin
            ab = 1'b1;
            break;
          end
          b = i / f.div;
          e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : f.data[b-1];
          if (tx !== e) errs++;
          if (b >= 1 && b <= 8 && (i % f.div) == f.div / 2) got[b-1] = tx;
        end
        if (!ab) begin
          check("frame_start_cycle", st, es);
          check("frame_data", {24'd0, got}, {24'd0, f.data});
          check("frame_bit_errors", errs, 0);
          prev_end = st + 10 * f.div;
        end
        mon_busy = 1'b0;
      end
    end
  end

  // Read monitor: every readdatavalid pops one expected response.
  always @(negedge clock) begin
    if (avs_readdatavalid === 1'b1) begin
      if (exp_reads.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_readvalid: data 0x%08h, required no response", avs_readdata);
      end else begin : rd_chk
        rd_t r;
        r = exp_reads.pop_front();
        check({r.name, "_latency"}, cyc, r.at);
        check(r.name, avs_readdata, r.data);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic bus_end();
    avs_write      = 1'b0;
    avs_read       = 1'b0;
    avs_byteenable = 4'd0;
  endtask

  // Starts and ends at a negedge; strobe stays high so calls can run back-to-back.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be,
                           output int acc, output int stalls);
    logic st;
    avs_write      = 1'b1;
    avs_address    = a;
    avs_writedata  = d;
    avs_byteenable = be;
    stalls         = 0;
    acc            = -1;
    for (int g = 0; g < 2000; g++) begin
      #1 st = avs_waitrequest;
      @(negedge clock);
      if (st !== 1'b1) begin
        acc = cyc;
        break;
      end
      stalls++;
    end
    if (acc < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL write_timeout: still stalled after %0d cycles, required acceptance", stalls);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, output int acc, output int stalls);
    bus_write(2'd0, {24'd0, d}, 4'b0001, acc, stalls);
    if (acc >= 0) exp_frames.push_back('{d, acc, model_div});
  endtask

  task automatic set_div(input logic [15:0] v);
    int a, s;
    bus_write(2'd3, {16'd0, v}, 4'b0011, a, s);
    bus_end();
    model_div = (v == 16'd0) ? 1 : int'(v);
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    exp_reads.push_back('{exp, cyc + 1, name});
    avs_read    = 1'b1;
    avs_address = a;
    @(negedge clock);
    avs_read = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int streak = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (exp_frames.size() == 0 && !mon_busy && tx === 1'b1) streak++;
      else streak = 0;
      if (streak >= 3) return;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL drain_timeout: %0d frames pending after %0d cycles, required 0", exp_frames.size(), budget);
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
  endtask

  initial begin
    #600000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, required completion");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, st, e1, s, acc17, st17;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_readvalid", {31'd0, avs_readdatavalid}, 32'd0);
    check("rst_readdata", avs_readdata, 32'd0);
    check("rst_waitrequest", {31'd0, avs_waitrequest}, 32'd0);
    bus_read(2'd1, 32'h4, "status_after_reset");
    bus_read(2'd3, 32'd434, "divisor_after_reset");
    bus_read(2'd2, 32'd0, "control_after_reset");
    bus_read(2'd0, 32'd0, "data_reads_zero");

    // Single frame, divisor 4
    set_div(16'd4);
    send_byte(8'hA5, acc, st);
    bus_end();
    wait_drain(200);

    // 18 contiguous writes at divisor 2: the 18th must stall until frame 2 pops
    set_div(16'd2);
    for (int k = 0; k < 18; k++) begin
      send_byte(8'($urandom_range(0, 255)), acc, st);
      if (k == 0) e1 = acc;
      if (k == 16) begin
        acc17 = acc;
        st17  = st;
      end
    end
    bus_end();
    check("burst17_no_stall", st17, 0);
    check("burst17_accept_cycle", acc17, e1 + 16);
    check("burst18_stalled", {31'd0, (st > 0)}, 32'd1);
    check("burst18_accept_cycle", acc, e1 + 22);
    wait_drain(800);

    // Interrupt behaviour, divisor 3
    set_div(16'd3);
    bus_write(2'd2, 32'h1, 4'b0001, acc, st);
    bus_end();
    idle(2);
    check("irq_idle_enabled", {31'd0, irq}, 32'd1);
    bus_read(2'd2, 32'h1, "control_readback");
    send_byte(8'h5C, acc, st);
    bus_end();
    idle(2);
    check("irq_drop_on_write", {31'd0, irq}, 32'd0);
    while (cyc < acc + 31) @(negedge clock);
    check("irq_low_at_stop_end", {31'd0, irq}, 32'd0);
    idle(1);
    check("irq_rise_after_stop", {31'd0, irq}, 32'd1);
    bus_write(2'd2, 32'h0, 4'b0001, acc, st);
    bus_end();
    wait_drain(200);

    // Lane 0 absent: no push. Then divisor 0 behaves as 1.
    bus_write(2'd0, 32'h0000_005A, 4'b1110, acc, st);
    bus_end();
    idle(3);
    bus_read(2'd1, 32'h4, "status_no_push");
    set_div(16'd0);
    bus_read(2'd3, 32'd0, "divisor_zero_readback");
    send_byte(8'h3C, acc, st);
    send_byte(8'hC3, acc, st);
    bus_end();
    wait_drain(200);

    // Randomised bursts with random divisors and gaps
    for (int r = 0; r < 5; r++) begin
      int d, n;
      d = $urandom_range(1, 5);
      set_div(16'(d));
      bus_read(2'd3, d, "divisor_readback");
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        send_byte(8'($urandom_range(0, 255)), acc, st);
        bus_end();
        idle($urandom_range(0, 25));
      end
      wait_drain(2000);
      bus_read(2'd1, 32'h4, "status_idle_after_burst");
    end

    // Reset in the middle of data bit 3
    set_div(16'd4);
    send_byte(8'h96, acc, st);
    bus_end();
    while (cyc < acc + 1 + 17) @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    check("reset_tx_high", {31'd0, tx}, 32'd1);
    #2 reset = 1'b0;
    exp_frames.delete();
    @(negedge clock);
    bus_read(2'd1, 32'h4, "status_after_midframe_reset");
    bus_read(2'd3, 32'd434, "divisor_after_midframe_reset");
    idle(100);
    check("tx_idle_after_reset", {31'd0, tx}, 32'd1);

    check("pending_frames", exp_frames.size(), 0);
    check("pending_reads", exp_reads.size(), 0);
    summary();
    $finish;
  end

endmodule

`default_nettype wire
